// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: converts a 5-bit binary value to two decimal digits by
// repeated subtraction, then scans both digits onto a shared active-low
// seven-segment bus (segment order GFEDCBA, an[0] = units, an[1] = tens).
// Optional build macro LEADING_ZERO_BLANK_EN blanks a zero tens digit.
module display_scan_ctrl #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [4:0] value,
  output logic       busy,
  output logic       done,
  output logic [6:0] seg,
  output logic [1:0] an
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  state_t     state, state_nxt;
  logic [4:0] rem, rem_nxt;
  logic [3:0] tens_acc, tens_acc_nxt;
  logic [3:0] tens_disp, tens_disp_nxt;
  logic [3:0] ones_disp, ones_disp_nxt;
  logic       done_nxt;

  logic [CW-1:0] cnt;
  logic          sel;
  logic [6:0]    seg_nxt;
  logic [1:0]    an_nxt;

  // Seven-segment pattern for one decimal digit, active low, GFEDCBA.
  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0011000;
      default: decode = 7'b1111111;
    endcase
  endfunction

  // Conversion FSM next-state: one subtraction of ten per CONV cycle, commit when rem < 10.
  always_comb begin
    // NOTE: every target gets a default before the case so no latch is inferred.
    state_nxt     = state;
    rem_nxt       = rem;
    tens_acc_nxt  = tens_acc;
    tens_disp_nxt = tens_disp;
    ones_disp_nxt = ones_disp;
    done_nxt      = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          rem_nxt      = value;
          tens_acc_nxt = 4'd0;
          state_nxt    = CONV;
        end
      end
      CONV: begin
        if (rem >= 5'd10) begin
          rem_nxt      = rem - 5'd10;
          tens_acc_nxt = tens_acc + 4'd1;
        end else begin
          tens_disp_nxt = tens_acc;
          ones_disp_nxt = rem[3:0];
          done_nxt      = 1'b1;
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Conversion state and display digit registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      state     <= IDLE;
      rem       <= 5'd0;
      tens_acc  <= 4'd0;
      tens_disp <= 4'd0;
      ones_disp <= 4'd0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      rem       <= rem_nxt;
      tens_acc  <= tens_acc_nxt;
      tens_disp <= tens_disp_nxt;
      ones_disp <= ones_disp_nxt;
      done      <= done_nxt;
    end
  end

  assign busy = (state == CONV);

  // Free-running refresh divider; sel flips each time the divider wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      sel <= 1'b0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      sel <= ~sel;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Pick the digit for the active slot and its anode enable.
  always_comb begin
    seg_nxt = decode(ones_disp);
    an_nxt  = 2'b10;
    if (sel) begin
`ifdef LEADING_ZERO_BLANK_EN
      if (tens_disp == 4'd0) begin
        seg_nxt = 7'b1111111;
        an_nxt  = 2'b11;
      end else begin
        seg_nxt = decode(tens_disp);
        an_nxt  = 2'b01;
      end
`else
      seg_nxt = decode(tens_disp);
      an_nxt  = 2'b01;
`endif
    end
  end

  // Registered display outputs so the bus is glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg <= 7'b1000000;
      an  <= 2'b10;
    end else begin
      seg <= seg_nxt;
      an  <= an_nxt;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench for display_scan_ctrl with REFRESH_DIV = 4. The stimulus
// side predicts which loads are accepted and queues the expected commit; the
// monitor pops on each done pulse and checks timing, busy and the scanned bus.
module tb_display_scan_ctrl;

  localparam int DIV = 4;

  typedef struct {
    int v;  // value loaded
    int a;  // edge index at which the load is accepted
    int c;  // edge index at which the digits are committed
  } item_t;

  localparam logic [6:0] SEG_TAB [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0011000
  };

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load;
  logic [4:0] value;
  logic       busy;
  logic       done;
  logic [6:0] seg;
  logic [1:0] an;

  int    n_cmp = 0;
  int    n_err = 0;
  int    cyc;
  int    free_edge = 0;
  item_t q[$];

  display_scan_ctrl #(.REFRESH_DIV(DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .value (value),
    .busy  (busy),
    .done  (done),
    .seg   (seg),
    .an    (an)
  );

  always #5 clk = ~clk;

  // Rising edges since reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string name, input int act, input int exp, input int t);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, t);
    end
  endtask

  // Expected bus for a given slot and digits.
  task automatic exp_bus(input int s, input int tens, input int ones,
                         output logic [6:0] es, output logic [1:0] ea);
    if (s == 0) begin
      es = SEG_TAB[ones];
      ea = 2'b10;
    end else begin
`ifdef LEADING_ZERO_BLANK_EN
      if (tens == 0) begin
        es = 7'b1111111;
        ea = 2'b11;
      end else begin
        es = SEG_TAB[tens];
        ea = 2'b01;
      end
`else
      es = SEG_TAB[tens];
      ea = 2'b01;
`endif
    end
  endtask

  // Drive one cycle of input; queue the commit if the load will be accepted.
  task automatic drive(input logic ld, input logic [4:0] v);
    item_t it;
    @(negedge clk);
    #1;
    load  = ld;
    value = v;
    if (ld && rst_n && (cyc + 1 >= free_edge)) begin
      it.v = int'(v);
      it.a = cyc + 1;
      it.c = it.a + it.v / 10 + 1;
      q.push_back(it);
      free_edge = it.c + 1;
    end
  endtask

  task automatic apply_reset(input int n);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    load  = 1'b0;
    free_edge = 0;
    repeat (n) @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  int         t;
  int         m_tens, m_ones;
  int         p_sel, p_tens, p_ones;
  logic       exp_busy;
  logic [6:0] es;
  logic [1:0] ea;
  item_t      it_m;

  initial begin
    m_tens = 0; m_ones = 0; p_sel = 0; p_tens = 0; p_ones = 0;
    forever begin
      @(negedge clk);
      t = cyc;
      if (!rst_n) begin
        check("rst_busy", busy, 0, t);
        check("rst_done", done, 0, t);
        check("rst_seg", seg, 7'b1000000, t);
        check("rst_an", an, 2'b10, t);
        q.delete();
        m_tens = 0; m_ones = 0; p_sel = 0; p_tens = 0; p_ones = 0;
      end else begin
        exp_bus(p_sel, p_tens, p_ones, es, ea);
        check("seg", seg, es, t);
        check("an", an, ea, t);
        exp_busy = (q.size() > 0) && (q[0].a <= t) && (t < q[0].c);
        check("busy", busy, exp_busy, t);
        if (done) begin
          if (q.size() == 0) begin
            check("done_spurious", 1, 0, t);
          end else begin
            it_m = q.pop_front();
            check("done_time", t, it_m.c, t);
            m_tens = it_m.v / 10;
            m_ones = it_m.v % 10;
          end
        end else if (q.size() > 0 && t >= q[0].c) begin
          it_m = q.pop_front();
          check("done_missing", 0, 1, t);
          m_tens = it_m.v / 10;
          m_ones = it_m.v % 10;
        end
        p_sel  = (t / DIV) % 2;
        p_tens = m_tens;
        p_ones = m_ones;
      end
    end
  end

  // Stimulus.
  initial begin
    rst_n = 1'b0;
    load  = 1'b0;
    value = 5'd0;
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b1;

    // Idle scan after reset.
    repeat (10) drive(1'b0, 5'd0);
    // 27 -> tens 2, units 7.
    drive(1'b1, 5'd27);
    repeat (12) drive(1'b0, 5'd0);
    // 31 -> maximum tens digit.
    drive(1'b1, 5'd31);
    repeat (12) drive(1'b0, 5'd0);
    // 25, then 9 on the second busy cycle (ignored).
    drive(1'b1, 5'd25);
    drive(1'b0, 5'd0);
    drive(1'b1, 5'd9);
    repeat (12) drive(1'b0, 5'd0);
    // 4 commits after one CONV cycle; 16 is loaded in its done cycle.
    drive(1'b1, 5'd4);
    drive(1'b0, 5'd0);
    drive(1'b1, 5'd16);
    repeat (12) drive(1'b0, 5'd0);
    // 7 -> zero tens digit.
    drive(1'b1, 5'd7);
    repeat (12) drive(1'b0, 5'd0);
    // 19, reset in the second CONV cycle: no commit, outputs back to reset.
    drive(1'b1, 5'd19);
    drive(1'b0, 5'd0);
    apply_reset(3);
    repeat (10) drive(1'b0, 5'd0);
    // Random traffic, including loads while busy and in done cycles.
    repeat (400) drive(($urandom_range(0, 2) == 0), 5'($urandom_range(0, 31)));
    repeat (10) drive(1'b0, 5'd0);

    check("queue_drained", q.size(), 0, cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 The block SHALL have parameter REFRESH_DIV, default 50000, meaning clk cycles per digit slot; legal range is 2 or more.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port load, input, 1 bit: conversion request, sampled in IDLE only.
REQ-005 The block SHALL have port value, input, 5 bits: unsigned binary 0..31, captured when load is accepted.
REQ-006 The block SHALL have port busy, output, 1 bit: high while a conversion is in progress.
REQ-007 The block SHALL have port done, output, 1 bit: one-cycle pulse when the new digits are committed.
REQ-008 The block SHALL have port seg, output, 7 bits: shared segment bus, order GFEDCBA, active low.
REQ-009 The block SHALL have port an, output, 2 bits: digit enables, active low; an[0] is units, an[1] is tens.

Function
REQ-010 The FSM SHALL have states IDLE and CONV; reset state is IDLE.
REQ-011 In IDLE with load=1 at an edge: rem<=value, tens_acc<=0, state<=CONV.
REQ-012 In CONV, each edge with rem>=10: rem<=rem-10, tens_acc<=tens_acc+1.
REQ-013 In CONV, at an edge with rem<10: tens_disp<=tens_acc, ones_disp<=rem[3:0] (both in the same edge), state<=IDLE, done<=1 for exactly the next cycle.
REQ-014 Committing a value v SHALL take floor(v/10)+1 CONV cycles; busy SHALL be high for exactly those cycles.
REQ-015 load while busy SHALL be ignored; no queuing occurs.
REQ-016 load=1 in the done cycle SHALL be accepted, since the FSM is already in IDLE.
REQ-017 rem SHALL be 5 bits; tens_acc, tens_disp and ones_disp SHALL be 4 bits; the maximum tens digit is 3.
REQ-018 The refresh counter SHALL count 0..REFRESH_DIV-1 and wrap to 0; sel SHALL toggle on each wrap.
REQ-019 sel=0 SHALL drive an=2'b10 and seg=decode(ones_disp); sel=1 SHALL drive an=2'b01 and seg=decode(tens_disp).
REQ-020 decode SHALL map 0..9 to 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0011000, and any other code to 1111111.
REQ-021 seg and an SHALL be registered: they change one edge after sel or the display registers change.
REQ-022 Scanning SHALL run continuously and independently of the FSM; a commit SHALL NOT reset the refresh counter or sel.

Reset
REQ-023 While rst_n=0: state=IDLE, busy=0, done=0, rem=0, tens_acc=0, tens_disp=0, ones_disp=0, counter=0, sel=0.
REQ-024 While rst_n=0: seg=7'b1000000 and an=2'b10.
REQ-025 Assertion of rst_n mid-conversion SHALL abort the conversion with no commit and no done pulse.
REQ-026 After rst_n deasserts, the first load SHALL be accepted at the first rising clk edge.

Configuration
REQ-027 With macro LEADING_ZERO_BLANK_EN defined: in sel=1 with tens_disp=0, the block SHALL drive seg=7'b1111111 and an=2'b11.
REQ-028 Without LEADING_ZERO_BLANK_EN: a zero tens digit SHALL be displayed as 1000000 with an=2'b01.
REQ-029 LEADING_ZERO_BLANK_EN SHALL NOT alter the FSM, the timing, or the units digit.

Verification (REFRESH_DIV=4)
REQ-030 Scenario 1: apply reset, release, keep load=0 -> seg=1000000, an=10 for 4 cycles, then an=01 with seg=1000000 (macro off); busy=0 and done=0 throughout.
REQ-031 Scenario 2: load with value=27 -> busy high 3 cycles, then done for 1 cycle; sel0 shows seg=1111000, sel1 shows seg=0100100.
REQ-032 Scenario 3: load with value=31 -> busy high 4 cycles; the digits shown are 3 (0110000) and 1 (1111001).
REQ-033 Scenario 4: load value=25, then load with value=9 on the 2nd busy cycle -> the second load is ignored and the display shows 25.
REQ-034 Scenario 5: load value=19, then rst_n=0 in the 2nd CONV cycle -> no done pulse; outputs return to the reset values.
REQ-035 Scenario 6: load with value=7, macro on -> sel1 shows seg=1111111, an=11; macro off -> sel1 shows seg=1000000, an=01.
